// File: rtl/bshift_pkg.sv
// Shared types for the serial-to-parallel receiver: bit order and FSM state.
package bshift_pkg;

  typedef enum logic {
    DIR_LSB_FIRST = 1'b0,
    DIR_MSB_FIRST = 1'b1
  } dir_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/bshift_deser_sreg.sv
// Direction-selectable serial-in shift register built from one 2:1 mux per bit.
// nxt is the value the register takes on an enabled edge, so a caller can capture a completed word.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module bshift_deser_sreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             si,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] q;

  // LSB-first shifts right with si entering at the top; MSB-first shifts left with si at bit 0.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic lsb_src;
    logic msb_src;
    if (b == WIDTH - 1) begin : g_top
      assign lsb_src = si;
    end else begin : g_mid
      assign lsb_src = q[b+1];
    end
    if (b == 0) begin : g_bot
      assign msb_src = si;
    end else begin : g_upper
      assign msb_src = q[b-1];
    end
    mux2x1 u_mux (
      .a (lsb_src),
      .b (msb_src),
      .s (dir),
      .y (nxt[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bshift_deser.sv
// Serial-to-parallel receiver: collects WIDTH bits in either order and hands each word
// to the consumer through a holding register with a valid/ready handshake.
module bshift_deser
  import bshift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i,
  input  logic             i_vld,
  input  logic             ssl,
  input  logic             sync,
  output logic [WIDTH-1:0] res,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             dbg_state
);

  // Handshake: a word transfers on any edge where res_vld && res_rdy. res_vld is
  // purely registered and never looks at res_rdy; res is stable while res_vld is high.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     state, state_nxt;
  dir_t             dir, dir_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             first;
  logic             done;
  logic             clr;
  logic             dir_eff;
  logic [WIDTH-1:0] word;

  assign dbg_state = state;

  // sync outranks collection; sync with i_vld restarts on the incoming bit.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    first     = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    if (sync && !i_vld) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      clr       = 1'b1;
    end else if (i_vld) begin
      if (sync || state == ST_IDLE) begin
        first     = 1'b1;
        dir_nxt   = dir_t'(ssl);
        cnt_nxt   = CW'(1);
        state_nxt = ST_COLLECT;
      end else if (cnt == LAST) begin
        done      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign dir_eff = first ? ssl : dir;

  bshift_deser_sreg #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (i_vld),
    .dir   (dir_eff),
    .si    (i),
    .nxt   (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dir   <= DIR_LSB_FIRST;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
      busy  <= (cnt_nxt != '0);
    end
  end

  // A completed word lands when the slot is empty or being drained this cycle; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res     <= '0;
      res_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (done && (!res_vld || res_rdy)) begin
        res     <= word;
        res_vld <= 1'b1;
      end else if (done) begin
        ovf <= 1'b1;
      end else if (res_vld && res_rdy) begin
        res_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bshift_deser.sv
// Directed bench for bshift_deser at WIDTH=4: bit order, ssl latching, overrun,
// sync restart, back-to-back handoff and mid-word reset.
module tb_bshift_deser;

  logic       clk;
  logic       rst_n;
  logic       i;
  logic       i_vld;
  logic       ssl;
  logic       sync;
  logic [3:0] res;
  logic       res_vld;
  logic       res_rdy;
  logic       busy;
  logic       ovf;
  logic       dbg_state;

  int n_cmp;
  int n_err;

  bshift_deser #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .i_vld     (i_vld),
    .ssl       (ssl),
    .sync      (sync),
    .res       (res),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .busy      (busy),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i     = b;
    i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
    i     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i       = 1'b0;
    i_vld   = 1'b0;
    ssl     = 1'b0;
    sync    = 1'b0;
    res_rdy = 1'b1;
    tick();
    tick();
    chk("rst_res", res, 4'h0);
    chk("rst_vld", res_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: LSB-first 1,1,0,1 -> B
    ssl = 1'b0;
    send_bit(1'b1);
    chk("t1_busy_b1", busy, 1'b1);
    chk("t1_state_b1", dbg_state, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t1_vld_early", res_vld, 1'b0);
    send_bit(1'b1);
    chk("t1_res", res, 4'hB);
    chk("t1_vld", res_vld, 1'b1);
    chk("t1_busy_done", busy, 1'b0);
    tick();
    chk("t1_vld_drop", res_vld, 1'b0);

    // 2: MSB-first 1,0,1,1 -> B; then 0,1,1,0 with ssl toggled after bit 1 -> 6
    ssl = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t2_res_a", res, 4'hB);
    tick();
    send_bit(1'b0);
    ssl = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t2_res_b", res, 4'h6);
    chk("t2_vld_b", res_vld, 1'b1);
    tick();

    // 3: overrun: hold A, drop 5
    res_rdy = 1'b0;
    ssl     = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t3_res_a", res, 4'hA);
    chk("t3_ovf_a", ovf, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t3_ovf_early", ovf, 1'b0);
    send_bit(1'b0);
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_res_held", res, 4'hA);
    chk("t3_vld_held", res_vld, 1'b1);
    tick();
    chk("t3_ovf_pulse", ovf, 1'b0);
    res_rdy = 1'b1;
    tick();
    chk("t3_vld_drop", res_vld, 1'b0);

    // 4: 2 bits, sync with i_vld (i=1), then 0,0,1 -> 9
    send_bit(1'b1);
    send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    chk("t4_busy_sync", busy, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t4_res", res, 4'h9);
    chk("t4_busy", busy, 1'b0);
    tick();

    // sync alone abandons a partial word
    send_bit(1'b1);
    send_bit(1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_busy", busy, 1'b0);
    chk("sync_state", dbg_state, 1'b0);
    chk("sync_vld", res_vld, 1'b0);

    // 5: back-to-back: hold 3, accept C in the completion cycle
    res_rdy = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("t5_res_a", res, 4'h3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    res_rdy = 1'b1;
    send_bit(1'b1);
    chk("t5_res_b", res, 4'hC);
    chk("t5_vld_b", res_vld, 1'b1);
    chk("t5_ovf", ovf, 1'b0);
    tick();
    chk("t5_vld_drop", res_vld, 1'b0);

    // 6: reset mid-word with a held word, then a fresh MSB-first D
    res_rdy = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_res_held", res, 4'h7);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_res", res, 4'h0);
    chk("t6_vld", res_vld, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ovf", ovf, 1'b0);
    chk("t6_state", dbg_state, 1'b0);
    res_rdy = 1'b1;
    ssl     = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t6_fresh", res, 4'hD);
    chk("t6_fresh_vld", res_vld, 1'b1);
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
